// File: rtl/ks10_intr_pkg.sv
// Shared state types and winner-selection helpers for dev_intr_arb.
// No ports: package imported by intr_src and dev_intr_arb.
package ks10_intr_pkg;

    localparam int MAXSRC = 16;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_ACT,
        SRC_WAIT,
        SRC_DONE
    } srcstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_VECTREAD,
        ARB_VECTCLR,
        ARB_SRCDONE
    } arbstate_t;

    // Lowest set index wins; returns 0 when nothing is requesting.
    function automatic logic [3:0] pick_fixed(
        input logic [MAXSRC-1:0] req
    );
        logic [3:0] sel;
        sel = '0;
        for (int k = MAXSRC - 1; k >= 0; k--) begin
            if (req[k])
                sel = 4'(k);
        end
        return sel;
    endfunction

    // First set index at or after ptr, wrapping modulo n.
    function automatic logic [3:0] pick_rr(
        input logic [MAXSRC-1:0] req,
        input logic [3:0]        ptr,
        input logic [4:0]        n
    );
        logic [3:0] sel;
        logic       found;
        logic [4:0] idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MAXSRC; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= n)
                idx = idx - n;
            if ((5'(k) < n) && !found && req[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/intr_src.sv
// One interrupt source: arms on rdy&ie, cleared by arbiter, re-arms after done.
// Ports: clk, rst, clr, ie, rdy, done, srcclr in; intr, isACT out.
module intr_src
    import ks10_intr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ie,
    input  logic rdy,
    input  logic done,
    input  logic srcclr,
    output logic intr,
    output logic isACT
);

    srcstate_t state;
    srcstate_t state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SRC_IDLE;
        else if (clr)
            state <= SRC_IDLE;
        else
            state <= state_n;
    end

    // done is only honoured once the vector has been taken, and must
    // drop again before a new rdy can re-arm the source.
    always_comb begin
        state_n = state;
        unique case (state)
            SRC_IDLE: if (rdy && ie)  state_n = SRC_ACT;
            SRC_ACT:  if (srcclr)     state_n = SRC_WAIT;
            SRC_WAIT: if (done)       state_n = SRC_DONE;
            SRC_DONE: if (!done)      state_n = SRC_IDLE;
            default:                  state_n = SRC_IDLE;
        endcase
    end

    assign isACT = (state == SRC_ACT);
    assign intr  = isACT && ie;

endmodule

// File: rtl/dev_intr_arb.sv
// N-source Unibus device interrupt controller with fixed/round-robin arbiter.
// Ports: clk, rst, clr, iack, ie[N], rdy[N], done[N] in;
//        intr[N], intrREQ, vecVALID, vecSEL[SELW] out.
module dev_intr_arb
    import ks10_intr_pkg::*;
#(
    parameter  int NSRC    = 2,
    parameter  int RR_MODE = 0,
    localparam int SELW    = ($clog2(NSRC) > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            iack,
    input  logic [NSRC-1:0] ie,
    input  logic [NSRC-1:0] rdy,
    input  logic [NSRC-1:0] done,
    output logic [NSRC-1:0] intr,
    output logic            intrREQ,
    output logic            vecVALID,
    output logic [SELW-1:0] vecSEL
);

    arbstate_t       state;
    arbstate_t       state_n;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_n;
    logic [SELW-1:0] sel_n;
    logic            valid_n;
    logic [SELW-1:0] pick;
    logic [SELW-1:0] sel_inc;
    logic [NSRC-1:0] act;
    logic [NSRC-1:0] srcclr;
    logic [MAXSRC-1:0] req;
    logic [3:0]      ptr4;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        intr_src u_src (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .ie     (ie[g]),
            .rdy    (rdy[g]),
            .done   (done[g]),
            .srcclr (srcclr[g]),
            .intr   (intr[g]),
            .isACT  (act[g])
        );
    end

    assign intrREQ = |intr;

    always_comb begin
        req            = '0;
        req[NSRC-1:0]  = intr;
        ptr4           = '0;
        ptr4[SELW-1:0] = ptr;
        if (RR_MODE != 0)
            pick = SELW'(pick_rr(req, ptr4, 5'(NSRC)));
        else
            pick = SELW'(pick_fixed(req));
    end

    assign sel_inc = (vecSEL == SELW'(NSRC - 1)) ? '0
                                                 : vecSEL + SELW'(1);

    always_comb begin
        srcclr = '0;
        if (state == ARB_SRCDONE) begin
            for (int i = 0; i < NSRC; i++)
                srcclr[i] = (vecSEL == SELW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            vecSEL   <= '0;
            vecVALID <= 1'b0;
            ptr      <= '0;
        end else if (clr) begin
            state    <= ARB_IDLE;
            vecSEL   <= '0;
            vecVALID <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            vecSEL   <= sel_n;
            vecVALID <= valid_n;
            ptr      <= ptr_n;
        end
    end

    // Selection tracks intr until iack; a masked-off or absent request
    // leaves the previous pick in place.
    always_comb begin
        state_n = state;
        sel_n   = vecSEL;
        valid_n = vecVALID;
        ptr_n   = ptr;
        unique case (state)
            ARB_IDLE: begin
                if (|act) begin
                    state_n = ARB_VECTREAD;
                    valid_n = 1'b0;
                end
            end
            ARB_VECTREAD: begin
                if (iack) begin
                    state_n = ARB_VECTCLR;
                end else if (|intr) begin
                    sel_n   = pick;
                    valid_n = 1'b1;
                end
            end
            ARB_VECTCLR: begin
                if (!iack)
                    state_n = vecVALID ? ARB_SRCDONE : ARB_IDLE;
            end
            ARB_SRCDONE: begin
                ptr_n = sel_inc;
                // The source being cleared still reads ACT this cycle.
                if (|(act & ~srcclr)) begin
                    state_n = ARB_VECTREAD;
                    valid_n = 1'b0;
                end else begin
                    state_n = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

endmodule
